// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default low-pass coefficients and dequantize helper for fir_decim
package fir_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_WRITE
    } state_t;

    localparam int QUANT_BITS = 10;

    // 32-tap audio low-pass; entry 0 weights the newest sample
    localparam logic signed [0:31][31:0] LPF_COEFF = {
        32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
        32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
        32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
        32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
        32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
        32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
        32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
        32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
    };

    // Divide by 2^QUANT_BITS truncating toward zero: negative products get a
    // bias of 2^QUANT_BITS-1 before the arithmetic shift so they round up.
    function automatic logic signed [31:0] dequantize(input logic signed [63:0] p);
        logic signed [63:0] shifted;
        if (p[63]) begin
            shifted = (p + 64'sd1023) >>> QUANT_BITS;
        end else begin
            shifted = p >>> QUANT_BITS;
        end
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - one tap of the filter: full-width signed multiply followed by dequantize
module fir_mac
    import fir_pkg::*;
(
    input  logic signed [31:0] coeff,
    input  logic signed [31:0] sample,
    output logic signed [31:0] term
);

    logic signed [63:0] product;

    // Both operands are signed, so the 64-bit context sign-extends them first
    assign product = coeff * sample;
    assign term    = dequantize(product);

endmodule

// File: rtl/fir_decim.sv
// rtl/fir_decim.sv - decimating FIR between two FWFT FIFOs; FIR_PARALLEL_MAC_EN selects a one-cycle adder tree MAC
module fir_decim
    import fir_pkg::*;
#(
    parameter int DECIMATION = 8,
    parameter int TAPS       = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic signed [0:TAPS-1][DATA_WIDTH-1:0] coeff = LPF_COEFF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    state_t                       state;
    state_t                       state_next;
    logic        [CNT_W-1:0]      count;
    logic signed [DATA_WIDTH-1:0] acc;
    logic signed [DATA_WIDTH-1:0] dline [TAPS];
    logic signed [DATA_WIDTH-1:0] mac_term;

`ifdef FIR_PARALLEL_MAC_EN
    logic signed [DATA_WIDTH-1:0] terms [TAPS];

    for (genvar g = 0; g < TAPS; g++) begin : g_tap
        fir_mac u_mac (
            .coeff  (coeff[g]),
            .sample (dline[g]),
            .term   (terms[g])
        );
    end

    // Sum every dequantized product; wrapping matches the sequential accumulator
    always_comb begin
        mac_term = '0;
        for (int i = 0; i < TAPS; i++) begin
            mac_term = mac_term + terms[i];
        end
    end
`else
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    logic [TAP_W-1:0] tap;

    fir_mac u_mac (
        .coeff  (coeff[tap]),
        .sample (dline[tap]),
        .term   (mac_term)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and FIFO strobes; strobes are gated by empty/full so neither FIFO is ever misused
    always_comb begin
        state_next  = state;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        y_out       = '0;
        case (state)
            S_LOAD: begin
                if (!x_in_empty) begin
                    x_in_rd_en = 1'b1;
                    if (count == CNT_LAST) begin
                        state_next = S_MAC;
                    end
                end
            end
            S_MAC: begin
`ifdef FIR_PARALLEL_MAC_EN
                state_next = S_WRITE;
`else
                if (tap == TAP_LAST) begin
                    state_next = S_WRITE;
                end
`endif
            end
            S_WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    y_out       = acc;
                    state_next  = S_LOAD;
                end
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // Delay line: every pop shifts history one slot older and inserts the FIFO head at slot 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
            end
        end else if (x_in_rd_en) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                dline[i] <= dline[i-1];
            end
            dline[0] <= x_in;
        end
    end

    // Pop counter and accumulator; the accumulator restarts on the last pop of each block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            acc   <= '0;
`ifndef FIR_PARALLEL_MAC_EN
            tap   <= '0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (x_in_rd_en) begin
                        if (count == CNT_LAST) begin
                            count <= '0;
                            acc   <= '0;
`ifndef FIR_PARALLEL_MAC_EN
                            tap   <= '0;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc + mac_term;
`ifndef FIR_PARALLEL_MAC_EN
                    tap <= tap + 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decim.sv
// tb/tb_fir_decim.sv - self-checking bench for fir_decim with FIFO models and a convolution reference
module tb_fir_decim;

    localparam int DEC   = 8;
    localparam int TAPS  = 32;
    localparam int DEPTH = 512;
`ifdef FIR_PARALLEL_MAC_EN
    localparam int MAC_CYC = 1;
`else
    localparam int MAC_CYC = TAPS;
`endif

    localparam int COEF [TAPS] = '{
        -3, -6, -12, -19, -27, -33, -30, -13,
        21, 78, 155, 249, 349, 446, 526, 579,
        579, 526, 446, 349, 249, 155, 78, 21,
        -13, -30, -33, -27, -19, -12, -6, -3
    };

    typedef struct {
        string name;
        int    kind;
        int    val;
        int    exp [5];
    } vec_t;

    logic        clk;
    logic        rst;
    logic        x_in_rd_en;
    logic        x_in_empty;
    logic [31:0] x_in;
    logic [31:0] y_out;
    logic        y_out_wr_en;
    logic        y_out_full;

    int inq [$];
    int outq [$];
    int sent [$];
    int push_cyc [$];
    int stall_pct;
    int force_full;
    int cyc;
    int viol_rd;
    int viol_wr;
    int checks;
    int errors;

    fir_decim dut (
        .clk         (clk),
        .rst         (rst),
        .x_in_rd_en  (x_in_rd_en),
        .x_in_empty  (x_in_empty),
        .x_in        (x_in),
        .y_out       (y_out),
        .y_out_wr_en (y_out_wr_en),
        .y_out_full  (y_out_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output j: convolution of the popped history with the taps, each product /1024 toward zero
    function automatic int model_out(input int j);
        int     acc;
        int     idx;
        longint p;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            idx = DEC * (j + 1) - 1 - k;
            if (idx >= 0 && idx < sent.size()) begin
                p = longint'(COEF[k]) * longint'(sent[idx]);
                acc = acc + int'(p / 1024);
            end
        end
        return acc;
    endfunction

    task automatic drive();
        x_in_empty = (inq.size() == 0) || (int'($urandom_range(99)) < stall_pct);
        x_in       = (inq.size() > 0) ? inq[0] : 32'd0;
        y_out_full = (force_full != 0) || (outq.size() >= DEPTH);
    endtask

    task automatic step();
        logic        rd;
        logic        wr;
        logic [31:0] y;
        @(negedge clk);
        rd = x_in_rd_en;
        wr = y_out_wr_en;
        y  = y_out;
        if (rd && x_in_empty) viol_rd++;
        if (wr && y_out_full) viol_wr++;
        @(posedge clk);
        #1;
        cyc++;
        if (rd && inq.size() > 0) sent.push_back(inq.pop_front());
        if (wr) begin
            outq.push_back(int'(y));
            push_cyc.push_back(cyc);
        end
        drive();
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        inq.delete();
        outq.delete();
        sent.delete();
        push_cyc.delete();
        stall_pct  = 0;
        force_full = 0;
        x_in_empty = 1'b1;
        x_in       = 32'd0;
        y_out_full = 1'b0;
        viol_rd    = 0;
        viol_wr    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive();
    endtask

    task automatic run_outputs(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (outq.size() < n && c < budget) begin
            step();
            c++;
        end
        chk({name, "_timeout_outputs"}, outq.size() >= n ? n : outq.size(), n);
    endtask

    task automatic check_model(input int n, input string name);
        for (int j = 0; j < n && j < outq.size(); j++) begin
            chk($sformatf("%s_out%0d", name, j), outq[j], model_out(j));
        end
    endtask

    function automatic int rand_sample();
        if ($urandom_range(3) == 0) return int'($urandom_range(4095)) - 2048;
        return int'($urandom);
    endfunction

    vec_t vecs [3];

    initial begin
        int held;
        int sent_mid;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b0;

        vecs[0] = '{name: "impulse",  kind: 0, val: 1024, exp: '{-13, 579, 21, -3, 0}};
        vecs[1] = '{name: "const1024", kind: 1, val: 1024, exp: '{-143, 2260, 4663, 4520, 4520}};
        vecs[2] = '{name: "constneg1", kind: 1, val: -1,   exp: '{0, 0, 0, 0, 0}};

        // Reset state
        do_reset();
        rst = 1'b0;
        #1;
        chk("reset_y_out", int'(y_out), 0);
        chk("reset_wr_en", int'(y_out_wr_en), 0);
        chk("reset_rd_en", int'(x_in_rd_en), 0);
        @(posedge clk);
        #1;

        // Directed table: impulse and constant inputs, no stalls
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                if (vecs[v].kind == 0) inq.push_back(i == 0 ? vecs[v].val : 0);
                else                   inq.push_back(vecs[v].val);
            end
            drive();
            run_outputs(5, 600, vecs[v].name);
            for (int j = 0; j < 5 && j < outq.size(); j++) begin
                chk($sformatf("%s_out%0d", vecs[v].name, j), outq[j], vecs[v].exp[j]);
            end
            if (push_cyc.size() >= 2) begin
                chk({vecs[v].name, "_interval"}, push_cyc[1] - push_cyc[0], DEC + MAC_CYC + 1);
            end
        end

        // Random samples with an intermittently empty input FIFO
        do_reset();
        stall_pct = 30;
        for (int i = 0; i < 30 * DEC; i++) inq.push_back(rand_sample());
        drive();
        run_outputs(30, 6000, "rand_stall");
        check_model(30, "rand_stall");
        chk("rand_stall_no_pop_empty", viol_rd, 0);
        chk("rand_stall_no_push_full", viol_wr, 0);

        // Output FIFO held full for 200 cycles
        do_reset();
        for (int i = 0; i < 25 * DEC; i++) inq.push_back(rand_sample());
        drive();
        run_outputs(3, 400, "full_pre");
        force_full = 1;
        drive();
        held     = outq.size();
        sent_mid = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (i == 60) sent_mid = sent.size();
        end
        chk("full_no_push_while_held", outq.size(), held);
        chk("full_no_pop_while_stuck", sent.size(), sent_mid);
        force_full = 0;
        drive();
        run_outputs(25, 3000, "full_post");
        check_model(25, "full");
        chk("full_no_push_full", viol_wr, 0);
        chk("full_no_pop_empty", viol_rd, 0);

        // Reset asserted while the MAC is running
        do_reset();
        for (int i = 0; i < DEC; i++) inq.push_back(1024);
        drive();
        repeat (DEC + 4) step();
        rst = 1'b0;
        #1;
        chk("midmac_y_out", int'(y_out), 0);
        chk("midmac_wr_en", int'(y_out_wr_en), 0);
        chk("midmac_no_early_out", outq.size(), 0);
        do_reset();
        repeat (MAC_CYC + 20) step();
        chk("midmac_nothing_emitted", outq.size(), 0);
        for (int i = 0; i < 2 * DEC; i++) inq.push_back(i == 0 ? 1024 : 0);
        drive();
        run_outputs(2, 400, "midmac_fresh");
        if (outq.size() >= 2) begin
            chk("midmac_fresh_out0", outq[0], -13);
            chk("midmac_fresh_out1", outq[1], 579);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
